dma_io_peripheral: RTL
======================

Name: dma_io_peripheral

Overview:
- Peripheral-side responder for the 8237A DMA channel interface. It is the device that raises DREQ and answers DACK together with the IOR_N/IOW_N strobes and EOP_N.
- Buffers transfer data in a local FIFO. The local logic pushes bytes that the DMA reads out (DMA write transfer) or pops bytes that the DMA delivers (DMA read transfer).
- Serves as both the synthesizable I/O device and the bench counterpart of the controller datapath.

Parameters:
- DW, 8, data width of DB and of the FIFO entries.
- DEPTH, 8, FIFO depth in entries (power of 2, at least 2).
- THRESH, 1, number of entries (WR mode) or free slots (RD mode) required before DREQ is raised.

Ports:
- CLK  in  1  system clock; all state is updated on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  out  1  DMA request, active high, registered.
- DACK  in  1  DMA acknowledge, active high.
- IOR_N  in  1  I/O read strobe from the controller; the peripheral drives DB while it is low.
- IOW_N  in  1  I/O write strobe from the controller; the peripheral captures DB.
- EOP_N  inout  1  end of process; input only unless DMA_PERIPH_EOP_GEN_EN is defined.
- DB  inout  DW  data bus; tri-stated unless driving.
- mode  in  1  0 = WR (peripheral to memory, uses IOR_N), 1 = RD (memory to peripheral, uses IOW_N).
- enable  in  1  arms the channel.
- push  in  1  local FIFO write.
- push_data  in  DW  local FIFO write data.
- pop  in  1  local FIFO read.
- pop_data  out  DW  FIFO head, valid while empty=0.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  number of FIFO entries.
- done  out  1  level, set when EOP is seen; cleared when enable is low.
- err  out  1  sticky underflow/overflow flag; cleared only by reset.

Behaviour:
- Reset values: DREQ=0, DB=z, EOP_N=z, count=0, empty=1, full=0, done=0, err=0, state=IDLE, FIFO pointers = 0.
- Reset asserted mid-transfer flushes the FIFO and drops DREQ immediately (asynchronous).
- Strobe edge detection:
  - ior_q and iow_q are registered copies of the strobes.
  - A strobe end is prev=0, now=1, with DACK=1.
  - A transfer is counted only at a strobe end.
- WR mode:
  - DB = FIFO head combinationally while DACK && !IOR_N; otherwise z.
  - Pop occurs at the IOR_N strobe end.
- RD mode:
  - DB is sampled on every cycle with DACK && !IOW_N; the last sample is captured.
  - Push occurs at the IOW_N strobe end.
- Request condition (cond):
  - WR mode: count >= THRESH.
  - RD mode: DEPTH - count >= THRESH.
- FSM states, encoded IDLE, REQ, XFER, DONE:
  - IDLE: DREQ=0. Latches mode. Goes to REQ when enable && cond.
  - REQ: DREQ=1. Goes to XFER on DACK=1. Goes to IDLE if enable=0 or cond is lost before DACK.
  - XFER: DREQ=1 while enable && the FIFO is not at its boundary.
    - DREQ drops the cycle after the strobe end that empties the FIFO (WR) or fills it (RD).
    - Goes to IDLE when DACK falls.
    - Goes to DONE when EOP_N=0 is sampled with DACK=1.
  - DONE: DREQ=0, done=1. Goes to IDLE when enable=0.
- mode changes outside IDLE are ignored.
- Simultaneous local and DMA FIFO access in the same cycle: both are applied and count is unchanged.
- Local push when full or pop when empty: ignored and err is set.
- DMA strobe end on an empty FIFO (WR): DB is driven 8'hFF, no pop occurs, err is set.
- DMA strobe end on a full FIFO (RD): the byte is dropped and err is set.
- enable=0 during XFER: DREQ drops the next cycle. Strobes are still honoured until DACK falls.
- EOP_N and DACK are sampled in the same cycle as a strobe end: the transfer completes first, then the FSM goes to DONE.
- FIFO pointers wrap modulo DEPTH. count is computed at full width so that full means count==DEPTH.

Optional Feature:
- Macro: DMA_PERIPH_EOP_GEN_EN.
- Defined:
  - Adds input xfer_len [15:0], latched at IDLE->REQ, and a down-counter decremented at each strobe end.
  - EOP_N is driven 0 while the counter==1 and DACK && strobe low; otherwise z (open drain).
  - The FSM enters DONE after that final strobe end.
  - xfer_len=0 means 65536 transfers.
- Undefined: EOP_N is input only, never driven, and xfer_len is absent.

Decomposition:
- Package dma_periph_pkg:
  - state_t enum (IDLE, REQ, XFER, DONE).
  - mode_t enum (WR=0, RD=1).
  - Constant UNDERFLOW_DATA = 8'hFF.
- Sub-module dma_periph_fifo: synchronous FIFO with dual push/pop ports, producing count, full and empty. The top-level muxes the local and DMA sides onto it per mode.

Test Plan:
- WR basic: push 3 bytes (A1, B2, C3), enable=1 -> DREQ=1 two cycles later. After DACK, three IOR_N pulses read A1, B2, C3 on DB. DREQ=0 the cycle after the third pulse; count=0.
- RD basic: empty FIFO, mode=1 -> DREQ asserted. DMA drives 5A, 6B on two IOW_N pulses -> pop_data=5A then 6B. err=0.
- Concurrent access: count=4 with one local push and one DMA pop in the same cycle -> count stays 4 and ordering is preserved.
- Error cases: IOR_N strobe end on an empty FIFO -> DB=FF, err=1, count=0. Local push when full -> err=1, count=DEPTH.
- EOP and reset:
  - EOP_N=0 mid-XFER -> DREQ=0 next cycle, done=1; done clears when enable drops.
  - RESET_N asserted mid-transfer -> DREQ=0, count=0 asynchronously.
- EOP generation (with DMA_PERIPH_EOP_GEN_EN): xfer_len=2 -> EOP_N=0 during the second strobe, then done=1.

Source files
------------

// File: rtl/dma_periph_pkg.sv
// rtl/dma_periph_pkg.sv - shared types and constants for the DMA I/O peripheral
//
// Contents:
//   state_t        : channel FSM states (IDLE, REQ, XFER, DONE)
//   mode_t         : transfer direction (WR = peripheral->memory, RD = memory->peripheral)
//   UNDERFLOW_DATA : value presented on DB when the DMA reads an empty FIFO
package dma_periph_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } mode_t;

  localparam logic [7:0] UNDERFLOW_DATA = 8'hFF;

endpackage

// File: rtl/dma_io_peripheral_if.sv
// rtl/dma_io_peripheral_if.sv - 8237A channel handshake signals between controller and peripheral
//
// Signals:
//   DREQ  : request, driven by the peripheral
//   DACK  : acknowledge, driven by the controller
//   IOR_N : I/O read strobe (active low), driven by the controller
//   IOW_N : I/O write strobe (active low), driven by the controller
// Modports:
//   master : controller side
//   slave  : peripheral side
interface dma_io_peripheral_if;

  logic DREQ;
  logic DACK;
  logic IOR_N;
  logic IOW_N;

  modport master (input DREQ, output DACK, output IOR_N, output IOW_N);
  modport slave  (output DREQ, input DACK, input IOR_N, input IOW_N);

endinterface

// File: rtl/dma_periph_fifo.sv
// rtl/dma_periph_fifo.sv - synchronous FIFO with one push port and one pop port
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   push_i/push_data_i : write request and data (ignored when full)
//   pop_i              : read request (ignored when empty)
//   pop_data_o         : head entry
//   full_o, empty_o    : occupancy flags
//   count_o            : current entry count
//   count_nxt_o        : entry count after this cycle's accepted operations
//   push_err_o         : push attempted while full
//   pop_err_o          : pop attempted while empty
module dma_periph_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o,
  output logic                     push_err_o,
  output logic                     pop_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Acceptance is judged on the pre-cycle occupancy, so a push into a full
  // FIFO is refused even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign push_err_o = push_i && full_o;
  assign pop_err_o  = pop_i && empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/dma_io_peripheral.sv
// rtl/dma_io_peripheral.sv - 8237A peripheral-side responder with local transfer FIFO
//
// Optional feature macro: DMA_PERIPH_EOP_GEN_EN (adds xfer_len and EOP_N generation).
// Ports:
//   CLK, RESET_N     : clock, asynchronous active-low reset
//   dma (slave)      : DREQ out, DACK/IOR_N/IOW_N in
//   EOP_N            : end of process (open drain when generation is enabled)
//   DB               : bidirectional data bus
//   mode, enable     : direction (0 WR, 1 RD) and channel arm
//   push, push_data  : local FIFO write (WR mode)
//   pop, pop_data    : local FIFO read and head (RD mode)
//   full, empty, count : FIFO status
//   done, err        : EOP seen (level), sticky over/underflow
//   xfer_len         : transfer count, only with DMA_PERIPH_EOP_GEN_EN
module dma_io_peripheral
  import dma_periph_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int THRESH = 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  dma_io_peripheral_if.slave     dma,
  inout  wire                    EOP_N,
  inout  wire  [DW-1:0]          DB,
  input  logic                   mode,
  input  logic                   enable,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   err
`ifdef DMA_PERIPH_EOP_GEN_EN
  ,
  input  logic [15:0]            xfer_len
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  state_t        state_q;
  mode_t         mode_q;
  logic          dreq_q, done_q, err_q;
  logic          ior_q, iow_q;
  logic [DW-1:0] rd_sample_q;

  logic          f_push, f_pop, f_full, f_empty, f_push_err, f_pop_err;
  logic [DW-1:0] f_push_data, f_head;
  logic [CW-1:0] f_count, f_count_nxt;

  logic is_wr, strobe_end, db_oe;
  logic cond_wr, cond_rd, cond, cond_idle, go_req, boundary_nxt;
  logic eop_seen, last_xfer;

  assign is_wr = (mode_q == WR);

  // A transfer completes on the rising edge of the active strobe while DACK is held.
  assign strobe_end = dma.DACK && (is_wr ? (!ior_q && dma.IOR_N) : (!iow_q && dma.IOW_N));

  // Local side feeds the FIFO in WR mode and drains it in RD mode; the DMA side is the opposite.
  assign f_push      = is_wr ? push : strobe_end;
  assign f_push_data = is_wr ? push_data : rd_sample_q;
  assign f_pop       = is_wr ? strobe_end : pop;

  dma_periph_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .push_i      (f_push),
    .push_data_i (f_push_data),
    .pop_i       (f_pop),
    .pop_data_o  (f_head),
    .full_o      (f_full),
    .empty_o     (f_empty),
    .count_o     (f_count),
    .count_nxt_o (f_count_nxt),
    .push_err_o  (f_push_err),
    .pop_err_o   (f_pop_err)
  );

  assign cond_wr = (f_count >= THRESH_C);
  assign cond_rd = ((DEPTH_C - f_count) >= THRESH_C);
  assign cond    = is_wr ? cond_wr : cond_rd;
  // IDLE latches mode on the same edge it decides to request, so it judges with the live input.
  assign cond_idle = (mode_t'(mode) == WR) ? cond_wr : cond_rd;
  assign go_req    = (state_q == IDLE) && enable && cond_idle;
  // Looking at next-cycle occupancy lets DREQ fall right after the emptying/filling strobe.
  assign boundary_nxt = is_wr ? (f_count_nxt == '0) : (f_count_nxt == DEPTH_C);

  assign db_oe = is_wr && dma.DACK && !dma.IOR_N;
  assign DB    = db_oe ? (f_empty ? DW'(UNDERFLOW_DATA) : f_head) : {DW{1'bz}};

`ifdef DMA_PERIPH_EOP_GEN_EN
  logic [16:0] xcnt_q;
  logic        eop_drive;

  assign eop_drive = (xcnt_q == 17'd1) && dma.DACK && (is_wr ? !dma.IOR_N : !dma.IOW_N);
  assign EOP_N     = eop_drive ? 1'b0 : 1'bz;
  // Our own EOP pulse is not an external terminal count.
  assign eop_seen  = !EOP_N && !eop_drive;
  assign last_xfer = strobe_end && (xcnt_q == 17'd1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      xcnt_q <= '0;
    end else if (go_req) begin
      xcnt_q <= (xfer_len == 16'd0) ? 17'h10000 : {1'b0, xfer_len};
    end else if (strobe_end && (xcnt_q != 17'd0)) begin
      xcnt_q <= xcnt_q - 17'd1;
    end
  end
`else
  assign eop_seen  = !EOP_N;
  assign last_xfer = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ior_q       <= 1'b1;
      iow_q       <= 1'b1;
      rd_sample_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ior_q <= dma.IOR_N;
      iow_q <= dma.IOW_N;
      if (!is_wr && dma.DACK && !dma.IOW_N) rd_sample_q <= DB;
      err_q <= err_q | f_push_err | f_pop_err;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      mode_q  <= WR;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mode_q <= mode_t'(mode);
          dreq_q <= 1'b0;
          done_q <= 1'b0;
          if (go_req) state_q <= REQ;
        end
        REQ: begin
          if (dma.DACK) begin
            state_q <= XFER;
            dreq_q  <= enable && !boundary_nxt;
          end else if (!enable || !cond) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
          end else begin
            dreq_q <= 1'b1;
          end
        end
        XFER: begin
          if ((eop_seen && dma.DACK) || last_xfer) begin
            state_q <= DONE;
            dreq_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!dma.DACK) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
          end else begin
            dreq_q <= enable && !boundary_nxt;
          end
        end
        DONE: begin
          dreq_q <= 1'b0;
          if (!enable) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          dreq_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dma.DREQ = dreq_q;
  assign pop_data = f_head;
  assign full     = f_full;
  assign empty    = f_empty;
  assign count    = f_count;
  assign done     = done_q;
  assign err      = err_q;

endmodule
